// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_seq_pkg
// Brief  : Shared constants and FSM state type for the register-file read sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_seq_pkg;

    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_read_sequencer_if
// Brief  : Instruction, writeback and operand handshake bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface regfile_read_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output instruction, instr_valid, RegWrite, WriteReg, WriteData, rd_ready,
        input  instr_ready, ReadData1, ReadData2, rd_valid
    );

    modport slave (
        input  instruction, instr_valid, RegWrite, WriteReg, WriteData, rd_ready,
        output instr_ready, ReadData1, ReadData2, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/regfile_1r1w.sv
`default_nettype none
// ============================================================================
// Module : regfile_1r1w
// Brief  : Register array, one combinational read port, one write port, x0 hardwired.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_1r1w #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [ADDR_W-1:0] i_readAddr,
    output logic      [DATA_W-1:0] o_readData,
    input  wire logic              i_writeEn,
    input  wire logic [ADDR_W-1:0] i_writeAddr,
    input  wire logic [DATA_W-1:0] i_writeData
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_writeEn && (i_writeAddr != '0)) begin
            r_mem[i_writeAddr] <= i_writeData;
        end
    end

    // x0 is never written, but forcing zero keeps the read independent of that
    assign o_readData = (i_readAddr == '0) ? '0 : r_mem[i_readAddr];

endmodule
`default_nettype wire

// File: rtl/regfile_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module : regfile_read_sequencer
// Brief  : Fetches rs1/rs2 over one read port in two serialized cycles.
//          REGFILE_WRITE_BYPASS_EN enables write-through forwarding on reads.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_read_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_IDX_W,
    parameter int NUM_REGS = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    regfile_read_sequencer_if.slave bus
);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] w_readAddr;
    logic [DATA_W-1:0] w_arrayData;
    logic [DATA_W-1:0] w_readData;
    logic [DATA_W-1:0] r_readData1;
    logic [DATA_W-1:0] r_readData2;
    logic              w_accept;
    logic              w_cap1;
    logic              w_cap2;
    logic              w_unusedInstrBits;

    assign w_unusedInstrBits = ^{bus.instruction[31:RS2_LSB+ADDR_W],
                                 bus.instruction[RS1_LSB-1:0]};

    regfile_1r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .i_readAddr  (w_readAddr),
        .o_readData  (w_arrayData),
        .i_writeEn   (bus.RegWrite),
        .i_writeAddr (bus.WriteReg),
        .i_writeData (bus.WriteData)
    );

`ifdef REGFILE_WRITE_BYPASS_EN
    assign w_readData = (bus.RegWrite && (bus.WriteReg == w_readAddr) && (bus.WriteReg != '0))
                      ? bus.WriteData : w_arrayData;
`else
    assign w_readData = w_arrayData;
`endif

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_cap1      = 1'b0;
        w_cap2      = 1'b0;
        w_readAddr  = r_rs1;
        case (r_state)
            IDLE: begin
                if (bus.instr_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = RD1;
                end
            end
            RD1: begin
                w_cap1 = 1'b1;
                // Identical operands need only one array access
                if (r_rs1 == r_rs2) begin
                    w_cap2      = 1'b1;
                    w_nextState = RESP;
                end else begin
                    w_nextState = RD2;
                end
            end
            RD2: begin
                w_readAddr  = r_rs2;
                w_cap2      = 1'b1;
                w_nextState = RESP;
            end
            RESP: begin
                if (bus.rd_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_readData1 <= '0;
            r_readData2 <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_rs1 <= bus.instruction[RS1_LSB +: ADDR_W];
                r_rs2 <= bus.instruction[RS2_LSB +: ADDR_W];
            end
            if (w_cap1) begin
                r_readData1 <= w_readData;
            end
            if (w_cap2) begin
                r_readData2 <= w_readData;
            end
        end
    end

    assign bus.instr_ready = (r_state == IDLE);
    assign bus.rd_valid    = (r_state == RESP);
    assign bus.ReadData1   = r_readData1;
    assign bus.ReadData2   = r_readData2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_read_sequencer
// Brief  : Scoreboard bench: directed scenarios plus randomized reads and writes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_read_sequencer;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model [32];
    exp_t        sbQ [$];

    regfile_read_sequencer_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_read_sequencer #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .NUM_REGS (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the architectural register image follows the edge
    task automatic cycle();
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (bus.RegWrite && bus.WriteReg != 5'd0) begin
            model[bus.WriteReg] = bus.WriteData;
        end
        @(negedge clk);
        bus.RegWrite    = 1'b0;
        bus.instr_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [4:0] idx, input logic [63:0] data);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = idx;
        bus.WriteData = data;
        cycle();
    endtask

    task automatic randWr(input logic [4:0] hint);
        if ($urandom_range(1, 0) == 1) begin
            bus.RegWrite  = 1'b1;
            bus.WriteReg  = ($urandom_range(1, 0) == 1) ? hint : 5'($urandom_range(31, 0));
            bus.WriteData = {$urandom, $urandom};
        end
    endtask

    // Value the read port yields for idx at the coming edge
    function automatic logic [63:0] capture(input logic [4:0] idx);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (bus.RegWrite && bus.WriteReg == idx && idx != 5'd0) return bus.WriteData;
`endif
        return model[idx];
    endfunction

    task automatic runInstr(input logic [31:0] instr, input int hold, input bit rnd,
                            input bit rd1Wr, input logic [4:0] rd1Idx, input logic [63:0] rd1Data,
                            input bit holdWr, input logic [4:0] holdIdx, input logic [63:0] holdData);
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] v1;
        logic [63:0] v2;
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        chkBit("instr_ready idle", bus.instr_ready, 1'b1);
        bus.instruction = instr;
        bus.instr_valid = 1'b1;
        if (rnd) randWr(rs1);
        cycle();
        chkBit("instr_ready busy", bus.instr_ready, 1'b0);
        chkBit("rd_valid early", bus.rd_valid, 1'b0);
        if (rd1Wr) begin
            bus.RegWrite  = 1'b1;
            bus.WriteReg  = rd1Idx;
            bus.WriteData = rd1Data;
        end else if (rnd) begin
            randWr(rs1);
        end
        v1 = capture(rs1);
        v2 = v1;
        cycle();
        if (rs1 != rs2) begin
            chkBit("instr_ready busy", bus.instr_ready, 1'b0);
            chkBit("rd_valid early", bus.rd_valid, 1'b0);
            if (rnd) randWr(rs2);
            v2 = capture(rs2);
            cycle();
        end
        sbQ.push_back('{v1, v2});
        chkBit("rd_valid latency", bus.rd_valid, 1'b1);
        chkBit("instr_ready resp", bus.instr_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            bus.rd_ready = 1'b0;
            if (holdWr) begin
                bus.RegWrite  = 1'b1;
                bus.WriteReg  = holdIdx;
                bus.WriteData = holdData;
            end else if (rnd) begin
                randWr(rs1);
            end
            cycle();
            chkBit("rd_valid held", bus.rd_valid, 1'b1);
        end
        bus.rd_ready = 1'b1;
        if (rnd) randWr(rs2);
        cycle();
        chkBit("instr_ready after resp", bus.instr_ready, 1'b1);
        chkBit("rd_valid after resp", bus.rd_valid, 1'b0);
    endtask

    // Monitor: compares every presented response against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.rd_valid) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected response: got %h/%h expected none",
                             bus.ReadData1, bus.ReadData2);
                end else begin
                    chk("ReadData1", bus.ReadData1, sbQ[0].d1);
                    chk("ReadData2", bus.ReadData2, sbQ[0].d2);
                    if (bus.rd_ready) void'(sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] instr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        reset           = 1'b0;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.WriteReg    = '0;
        bus.WriteData   = '0;
        bus.rd_ready    = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b1;
        chkBit("reset instr_ready", bus.instr_ready, 1'b1);
        chkBit("reset rd_valid", bus.rd_valid, 1'b0);
        chk("reset ReadData1", bus.ReadData1, 64'd0);
        chk("reset ReadData2", bus.ReadData2, 64'd0);

        // Basic read
        doWrite(5'd30, 64'hAAAA_0000_0000_001E);
        doWrite(5'd31, 64'h5555_0000_0000_001F);
        runInstr(32'h01EF8000, 0, 0, 0, '0, '0, 0, '0, '0);

        // Back-to-back with registers holding their own index
        for (int i = 1; i < 32; i++) doWrite(5'(i), 64'(i));
        runInstr(32'h01CE8000, 0, 0, 0, '0, '0, 0, '0, '0);
        runInstr(32'h00E78000, 0, 0, 0, '0, '0, 0, '0, '0);

        // Equal operands and x0
        runInstr(32'h00528000, 0, 0, 0, '0, '0, 0, '0, '0);
        doWrite(5'd0, 64'hFFFF);
        runInstr(32'h00000000, 0, 0, 0, '0, '0, 0, '0, '0);

        // Backpressure with a write to the captured register
        runInstr(32'h01EF8000, 5, 0, 0, '0, '0, 1, 5'd31, 64'h1234);

        // Same-cycle collision on rs1
        runInstr(32'h01EF8000, 0, 0, 1, 5'd31, 64'hBEEF, 0, '0, '0);

        // Reset during RD2
        bus.instruction = 32'h01CE8000;
        bus.instr_valid = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chkBit("midreset instr_ready", bus.instr_ready, 1'b1);
        chkBit("midreset rd_valid", bus.rd_valid, 1'b0);
        chk("midreset ReadData1", bus.ReadData1, 64'd0);
        chk("midreset ReadData2", bus.ReadData2, 64'd0);
        runInstr(32'h01CE8000, 0, 0, 0, '0, '0, 0, '0, '0);

        // Randomized traffic
        for (int i = 1; i < 32; i++) doWrite(5'(i), {$urandom, $urandom});
        for (int n = 0; n < 40; n++) begin
            r1 = 5'($urandom_range(31, 0));
            r2 = ($urandom_range(3, 0) == 0) ? r1 : 5'($urandom_range(31, 0));
            instr = $urandom;
            instr[19:15] = r1;
            instr[24:20] = r2;
            runInstr(instr, int'($urandom_range(3, 0)), 1, 0, '0, '0, 0, '0, '0);
        end

        cycle();
        chk("scoreboard drained", 64'(sbQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_read_sequencer.md
Name: regfile_read_sequencer

Overview:
Decodes rs1/rs2 from a 32-bit RISC-V instruction and fetches both operands from a single-read-port, single-write-port 32x64 register file.
- Reads are serialized over two cycles under an FSM.
- Instructions are accepted, and results delivered, through valid/ready handshakes.
- The block sits between instruction fetch/decode and the ALU operand registers, replacing the two-read-port register file top.

Parameters:
- DATA_W, 64, register width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- instruction  in  32  rs1 = [19:15], rs2 = [24:20].
- instr_valid  in  1  instruction presented.
- instr_ready  out  1  block can accept an instruction.
- RegWrite  in  1  write enable from writeback.
- WriteReg  in  ADDR_W  write index.
- WriteData  in  DATA_W  write data.
- ReadData1  out  DATA_W  value of rs1.
- ReadData2  out  DATA_W  value of rs2.
- rd_valid  out  1  operands valid.
- rd_ready  in  1  consumer accepts operands.

Behaviour:
- Reset (reset==0 at an edge):
  - state IDLE.
  - ReadData1 = ReadData2 = 0, rd_valid = 0.
  - All NUM_REGS registers cleared to 0.
  - Applies mid-operation: any in-flight read is aborted, no response is produced, and the latched instruction is discarded.
- instr_ready = 1 only in IDLE, driven combinationally from state. rd_valid = 1 only in RESP.
- FSM:
  - IDLE: on instr_valid, latch rs1/rs2 and go to RD1.
  - RD1: read-port address = rs1; capture the result into ReadData1.
    - If rs1 == rs2, also capture into ReadData2 and go to RESP.
    - Otherwise go to RD2.
  - RD2: read-port address = rs2; capture into ReadData2; go to RESP.
  - RESP: hold outputs; on rd_ready, go to IDLE.
- Latency: handshake sampled at the end of cycle N gives rd_valid in cycle N+3, or N+2 when rs1 == rs2.
- Throughput: at most one instruction per 4 cycles. No new acceptance occurs in the cycle RESP completes; IDLE is re-entered first.
- Register x0 reads 0 always. Writes with WriteReg == 0 are ignored.
- Writes are accepted in every state, independent of the FSM. The write commits at the clock edge.
- ReadData1/2 are snapshots: a write to rs1/rs2 after capture does not change the outputs while in RESP.
- Same-cycle write and read to the same nonzero index: the captured value is the old array content (see Optional Feature).
- Index width rule: indices are taken verbatim from the instruction fields. With NUM_REGS = 32 there is no out-of-range case.
- Outputs remain stable while rd_valid = 1 and rd_ready = 0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RD1/RD2, if RegWrite = 1, WriteReg == the current read address, and WriteReg != 0, then WriteData is captured instead of the array value (write-through forwarding).
- Undefined: the array value from before the write is captured.

Decomposition:
- Package regfile_seq_pkg holds:
  - state enum {IDLE, RD1, RD2, RESP};
  - constants RS1_LSB = 15, RS2_LSB = 20, REG_IDX_W = 5, XLEN = 64.
- Sub-module regfile_1r1w, the storage array:
  - one combinational read port;
  - one synchronous write port with x0 write suppression;
  - synchronous active-low clear.
- The FSM, capture registers and optional bypass mux live in regfile_read_sequencer.

Test Plan:
1. Basic read:
   - Reset.
   - Write x30 = 64'hAAAA_0000_0000_001E and x31 = 64'h5555_0000_0000_001F.
   - Present instruction 32'h01EF8000 with rd_ready = 1.
   - Expect ReadData1 = x31 value, ReadData2 = x30 value, and rd_valid exactly in cycle N+3.
2. Back-to-back instructions:
   - Present 32'h01CE8000 (rs1 = 29, rs2 = 28), then 32'h00E78000 (rs1 = 15, rs2 = 14), with registers preloaded to their own index value.
   - Expect (29, 28), then (15, 14).
   - instr_ready must be low from acceptance until IDLE.
3. Equal operands and x0:
   - Instruction with rs1 = rs2 = 5 gives rd_valid in cycle N+2, both outputs = x5.
   - Writing x0 = 64'hFFFF then reading rs1 = rs2 = 0 gives 0.
4. Backpressure and snapshot:
   - Hold rd_ready = 0 for 5 cycles while writing x31 = 64'h1234.
   - Outputs keep the old x31 value; rd_valid stays 1; the response completes when rd_ready = 1.
5. Same-cycle collision:
   - Write x31 = 64'hBEEF in the RD1 cycle of 32'h01EF8000.
   - ReadData1 = old value without REGFILE_WRITE_BYPASS_EN, 64'hBEEF with it.
6. Reset mid-operation:
   - Assert reset = 0 during RD2.
   - Next cycle: IDLE, rd_valid = 0, outputs 0.
   - A subsequent read of any register returns 0.
